// File: rtl/fetch_ifid_stage.sv
// ============================================================================
// fetch_ifid_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage core.
// Holds the fetch PC, drives the instruction memory address, and latches the
// returned word into IF/ID. The latched opcode field goes straight to the
// instruction-type decoder in ID.
//
// State machine (bubble tracking):
//   state | meaning
//   FILL  | IF/ID holds a bubble (after reset or redirect), o_ifid_valid = 0
//   RUN   | IF/ID holds a real fetched instruction, o_ifid_valid = 1
//
// Per-cycle priority: reset > redirect > stall > advance.
//
// Optional feature: define FETCH_PERF_EN to add three saturating 32-bit
// performance counters (fetched / stalls / flushes) and their output ports.
//
// Ports:
//   i_clock          single clock, rising edge
//   i_reset          synchronous, active-high reset
//   o_imem_addr      instruction memory word address (= o_pc)
//   i_imem_q         instruction memory read data, same cycle as o_imem_addr
//   i_stall          hold PC and IF/ID
//   i_redirect       branch/jump taken in EX: flush IF/ID, load i_redirect_pc
//   i_redirect_pc    redirect target address
//   o_pc             current fetch PC
//   o_ifid_insn      latched instruction
//   o_ifid_pc1       PC+1 of the latched instruction
//   o_ifid_valid     1 = real instruction, 0 = bubble
//   o_ifid_opcode    o_ifid_insn[DATA_W-1:DATA_W-5]
//   o_perf_fetched   (FETCH_PERF_EN) advance cycles
//   o_perf_stalls    (FETCH_PERF_EN) stall cycles without redirect
//   o_perf_flushes   (FETCH_PERF_EN) redirect cycles
// ============================================================================
module fetch_ifid_stage #(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [DATA_W-1:0] i_imem_q,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_ifid_insn,
    output logic [ADDR_W-1:0] o_ifid_pc1,
    output logic              o_ifid_valid,
    output logic [4:0]        o_ifid_opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       o_perf_fetched,
    output logic [31:0]       o_perf_stalls,
    output logic [31:0]       o_perf_flushes
`endif
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_insn;
    logic [ADDR_W-1:0]   r_pc1;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_advance;

    // Redirect wins over stall, so an advance needs both low.
    assign w_advance = ~i_redirect & ~i_stall;
    // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
    assign w_pc_inc  = r_pc + PC_ONE;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (i_redirect) begin
            w_state_nxt = S_FILL;
        end else if (!i_stall) begin
            w_state_nxt = S_RUN;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_ifid_valid = (r_state == S_RUN);
    end

    // ------------------------------------------------------------------
    // PC and IF/ID datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc   <= '0;
            r_insn <= NOP_WORD;
            r_pc1  <= '0;
        end else if (i_redirect) begin
            // The word fetched this cycle belongs to the wrong path.
            r_pc   <= i_redirect_pc;
            r_insn <= NOP_WORD;
            r_pc1  <= '0;
        end else if (w_advance) begin
            r_pc   <= w_pc_inc;
            r_insn <= i_imem_q;
            r_pc1  <= w_pc_inc;
        end
    end

    assign o_pc          = r_pc;
    assign o_imem_addr   = r_pc;
    assign o_ifid_insn   = r_insn;
    assign o_ifid_pc1    = r_pc1;
    assign o_ifid_opcode = r_insn[DATA_W-1 -: 5];

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_advance && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (i_stall && !i_redirect && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
            if (i_redirect && (r_perf_flushes != 32'hFFFF_FFFF)) begin
                r_perf_flushes <= r_perf_flushes + 32'd1;
            end
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_stalls  = r_perf_stalls;
    assign o_perf_flushes = r_perf_flushes;
`endif

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage core.
- Holds the PC, addresses instruction memory, and latches the fetched word into IF/ID.
- Presents the latched opcode field (insn[31:27]) directly to the instruction-type decoder in ID.
- Supports stall from hazard control and redirect/flush from the branch/jump resolution logic in EX.

Parameters:
ADDR_W, 12, PC / imem address width in words; PC wraps modulo 2^ADDR_W
DATA_W, 32, instruction width; opcode is bits [DATA_W-1:DATA_W-5]
NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush (R-type opcode 00000, all-zero fields)

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_addr  out  ADDR_W  instruction memory word address, equals pc (combinational from pc register)
imem_q  in  DATA_W  instruction memory read data, combinational, valid same cycle as imem_addr
stall  in  1  hold PC and IF/ID (load-use hazard / multdiv busy)
redirect  in  1  branch/jump taken in EX; flush IF/ID and load redirect_pc
redirect_pc  in  ADDR_W  target address for redirect
pc  out  ADDR_W  current fetch PC
ifid_insn  out  DATA_W  latched instruction
ifid_pc1  out  ADDR_W  latched PC+1 of the latched instruction (for jal/branch offset)
ifid_valid  out  1  1 = ifid_insn is a real fetched instruction, 0 = bubble
ifid_opcode  out  5  ifid_insn[DATA_W-1:DATA_W-5], wired to decoder op input

Behaviour:
- Reset (sampled at clock edge, highest priority): pc=0, ifid_insn=NOP_WORD, ifid_pc1=0, ifid_valid=0; perf counters (if enabled) = 0. Reset mid-stall or mid-redirect discards both.
- Per-cycle priority: reset > redirect > stall > advance.
- Advance (no stall, no redirect): pc <= pc+1 (mod 2^ADDR_W; 0xFFF -> 0x000 at default), ifid_insn <= imem_q, ifid_pc1 <= pc+1 (same wrap), ifid_valid <= 1.
- Stall only: pc, ifid_insn, ifid_pc1, ifid_valid all hold. imem_addr stays at pc, so the same word is re-fetched when the stall releases.
- Redirect (regardless of stall): pc <= redirect_pc, ifid_insn <= NOP_WORD, ifid_pc1 <= 0, ifid_valid <= 0. The instruction fetched that cycle is discarded.
- Redirect on consecutive cycles: each cycle loads the newest redirect_pc and keeps the bubble.
- Latency:
  - imem_addr to ifid_insn is 1 cycle.
  - Redirect to first valid target instruction in IF/ID is 2 edges: edge 1 loads pc, edge 2 latches the target word.
- ifid_opcode is purely combinational from ifid_insn; a bubble therefore reads as opcode 00000 (R-type), and downstream must qualify with ifid_valid.
- Internal state machine, 2 states, for bubble tracking:
  - FILL: after reset or redirect; ifid_valid=0.
  - RUN: ifid_valid=1.
  - FILL->RUN on advance; RUN->FILL on redirect; stall holds the state.
  - ifid_valid is the registered state bit.
- No X propagation: every register has a defined reset value; imem_q is sampled only on advance.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds output ports perf_fetched, perf_stalls, perf_flushes, 32 bits each, all reset to 0. Each saturates at 32'hFFFF_FFFF and does not wrap.
  - perf_fetched increments on advance cycles.
  - perf_stalls increments on cycles with stall=1 and redirect=0.
  - perf_flushes increments on redirect cycles.
- When undefined, these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Reset, then 4 free-run cycles with imem_q = 32'h0800_0005, 0x1, 0x2, 0x3 -> pc steps 0,1,2,3,4; ifid_pc1 = 1..4; ifid_valid=1 from the first edge; ifid_opcode=00001 for the first word.
- Stall held 3 cycles at pc=5 -> pc, ifid_insn and ifid_valid unchanged for 3 edges; on release ifid_insn = imem_q at address 5 and pc=6.
- Redirect with redirect_pc=0x100 while stall=1 -> next edge: pc=0x100, ifid_valid=0, ifid_insn=0; following edge: ifid_valid=1, ifid_pc1=0x101.
- Free-run from pc=0xFFF -> pc=0x000, ifid_pc1=0x000, no stall or flush.
- Assert reset during a redirect cycle with redirect_pc=0x20 -> pc=0, ifid_valid=0; 0x20 is never loaded.
- With FETCH_PERF_EN: 10 advance, 3 stall, 2 redirect cycles -> perf_fetched=10, perf_stalls=3, perf_flushes=2. With perf_fetched preloaded (forced) to 32'hFFFF_FFFF, a further advance leaves it at 32'hFFFF_FFFF.
